sd_adder_pipe: RTL and testbench
================================

// Module: sd_adder_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined signed-digit (redundant binary) adder with valid/ready flow control.
//  Uses previous-digit information, so the carry never ripples.
//  Also flags illegal digit codes for fault tolerance and converts each result to two's complement.
//  Sits between signed-digit producers and binary consumers in the adder datapath.
// PARAMETERS
//  NDIG   4  number of signed digits per operand (>=2)
//  CNT_W  8  width of the saturating error counter
// PORTS
//  clk        in   1          rising-edge clock (single clock domain)
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          operand handshake valid
//  in_ready   out  1          operand handshake ready
//  in_a       in   2*NDIG     operand A; digit i = in_a[2i+1:2i]
//  in_b       in   2*NDIG     operand B; same digit layout as in_a
//  in_cin     in   1          carry-in, weight +1 at digit 0
//  out_valid  out  1          result handshake valid
//  out_ready  in   1          result handshake ready
//  out_sum    out  2*NDIG     result digits s[NDIG-1:0]
//  out_cout   out  2          carry-out digit t[NDIG-1]
//  out_value  out  NDIG+2     signed two's-complement value of {out_cout, out_sum}
//  out_err    out  1          illegal digit code seen in this transaction
//  err_clr    in   1          synchronous clear of err_cnt
//  err_cnt    out  CNT_W      saturating count of accepted erroneous transactions
// BEHAVIOUR
//  Digit code: 00=0, 01=+1, 11=-1, 10=illegal.
//  Per digit i: z=a_i+b_i in -2..2; P_i=1 iff a_{i-1} or b_{i-1} is negative; P_0=0.
//  (t,w) mapping:
//    z=+2 -> (+1,0); z=-2 -> (-1,0); z=0 -> (0,0)
//    z=+1 -> P=0: (+1,-1), P=1: (0,+1)
//    z=-1 -> P=0: (0,-1),  P=1: (-1,+1)
//  Result digits: s_i = w_i + t_{i-1} for i>=1; s_0 = w_0 + in_cin. Each s_i is always in -1..+1.
//  out_cout = t_{NDIG-1}.
//  out_value = sum(s_i*2^i) + cout*2^NDIG; sign-extended to NDIG+2 bits, never overflows.
//  Stage A: on in_valid&&in_ready, registers t, w, cin, err.
//    err = any digit of in_a/in_b == 2'b10.
//  Stage B: registers out_sum, out_cout, out_value, out_err from stage A.
//  Latency: exactly 2 cycles from accept to out_valid when not stalled; throughput 1/cycle.
//  Stall: B holds while out_valid && !out_ready.
//    A advances when B is empty or draining.
//    in_ready = !A_valid || A_advances; combinational from out_ready, no skid buffer.
//  Order is preserved; no transaction is dropped or duplicated.
//  Outputs are stable while out_valid && !out_ready.
//  Error transaction: out_err=1, out_sum=0, out_cout=0, out_value=0.
//    Errors do not stall the pipeline.
//  err_cnt: +1 when an erroneous transaction is accepted; saturates at 2^CNT_W-1.
//    err_clr has priority: a same-cycle increment is lost.
//  Reset: A/B valid=0, out_valid=0, out_sum=0, out_cout=0, out_value=0, out_err=0, err_cnt=0.
//    in_ready=1 the cycle after reset deasserts.
//  Reset mid-operation flushes all in-flight transactions; none emerge afterwards.
// TESTING (NDIG=4, out_ready=1 unless stated)
//  1. a=8'b00000001, b=8'b00000001, cin=0
//     -> 2 cycles later out_sum=8'b00000100, cout=00, value=2, err=0.
//  2. a=b=8'b01010101 (15), cin=1
//     -> out_sum=8'b01010101, cout=01, value=31.
//  3. Previous-digit case: a=8'b00000100 (+2), b=8'b00000011 (-1)
//     -> out_sum=8'b00000111, value=+1.
//  4. a=8'b00000010 (illegal)
//     -> out_err=1, out_sum=0, value=0, err_cnt 0->1.
//     Then err_clr together with another illegal input -> err_cnt=0.
//  5. Backpressure: out_ready=0 for 5 cycles, 4 back-to-back inputs
//     -> 2 accepted then in_ready=0.
//     Release -> results in input order, one per cycle.
//  6. Assert rst with 2 transactions in flight
//     -> out_valid=0 next cycle, err_cnt=0, no stale result after release.
//  Also: random legal operands vs behavioural model; out_value == value(a)+value(b)+cin.

Source files
------------

// File: rtl/sd_adder_pipe.sv
// sd_adder_pipe: 2-stage pipelined signed-digit adder with valid/ready flow control,
// illegal-digit detection and two's-complement conversion of each result.
module sd_adder_pipe #(
    parameter int NDIG  = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*NDIG-1:0] in_a,
    input  logic [2*NDIG-1:0] in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NDIG-1:0] out_sum,
    output logic [1:0]        out_cout,
    output logic [NDIG+1:0]   out_value,
    output logic              out_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
);
    logic [NDIG-1:0]   neg, bad, p;
    logic [2*NDIG-1:0] t_d, w_d, t_q, w_q, tc, s;
    logic [NDIG+1:0]   value;
    logic              a_valid, b_valid, cin_q, err_q, b_adv, in_fire;

    assign b_adv     = !b_valid || out_ready;
    assign in_ready  = !a_valid || b_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = b_valid;
    assign p         = {neg[NDIG-2:0], 1'b0};
    // incoming transfer into digit i: t_{i-1}, with the carry-in at digit 0
    assign tc        = {t_q[2*NDIG-3:0], 1'b0, cin_q};

    // digit codes are 2-bit two's complement, so sign-extended adds give z directly
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        logic [2:0] z;
        assign neg[g] = in_a[2*g+:2] == 2'b11 || in_b[2*g+:2] == 2'b11;
        assign bad[g] = in_a[2*g+:2] == 2'b10 || in_b[2*g+:2] == 2'b10;
        assign z = {in_a[2*g+1], in_a[2*g+:2]} + {in_b[2*g+1], in_b[2*g+:2]};
        assign t_d[2*g+:2] = (z == 3'b010 || (z == 3'b001 && !p[g])) ? 2'b01 :
                             (z == 3'b110 || (z == 3'b111 && p[g])) ? 2'b11 : 2'b00;
        assign w_d[2*g+:2] = (z == 3'b001 || z == 3'b111) ? (p[g] ? 2'b01 : 2'b11) : 2'b00;
        assign s[2*g+:2] = w_q[2*g+:2] + tc[2*g+:2];
    end

    always_comb begin
        value = {{NDIG{t_q[2*NDIG-1]}}, t_q[2*NDIG-1-:2]} << NDIG;
        for (int i = 0; i < NDIG; i++)
            value = value + ({{NDIG{s[2*i+1]}}, s[2*i+:2]} << i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            t_q       <= '0;
            w_q       <= '0;
            cin_q     <= 1'b0;
            err_q     <= 1'b0;
            out_sum   <= '0;
            out_cout  <= '0;
            out_value <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (in_fire) begin
                t_q   <= t_d;
                w_q   <= w_d;
                cin_q <= in_cin;
                err_q <= |bad;
            end
            a_valid <= in_fire || (a_valid && !b_adv);
            if (b_adv)
                b_valid <= a_valid;
            if (b_adv && a_valid) begin
                out_sum   <= err_q ? '0 : s;
                out_cout  <= err_q ? '0 : t_q[2*NDIG-1-:2];
                out_value <= err_q ? '0 : value;
                out_err   <= err_q;
            end
            if (err_clr)
                err_cnt <= '0;
            else if (in_fire && |bad && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sd_adder_pipe.sv
// tb_sd_adder_pipe: directed and randomized checks of sd_adder_pipe against an
// integer-arithmetic model of the signed-digit rules.
module tb_sd_adder_pipe;
    localparam int N  = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic [2*N-1:0] sum;
        logic [1:0]     cout;
        logic [N+1:0]   value;
        logic           err;
        logic [N+1:0]   ar;
    } exp_t;

    logic           clk = 0, rst = 1, in_valid = 0, in_cin = 0, out_ready = 1, err_clr = 0;
    logic [2*N-1:0] in_a = '0, in_b = '0;
    logic           in_ready, out_valid, out_err;
    logic [2*N-1:0] out_sum;
    logic [1:0]     out_cout;
    logic [N+1:0]   out_value;
    logic [CW-1:0]  err_cnt;

    int n_chk = 0, n_fail = 0, n_out = 0, cnt_m = 0;
    bit mon_en = 0, held = 0;
    logic [2*N+N+4:0] h;
    exp_t q[$];
    exp_t e, mm;

    sd_adder_pipe #(.NDIG(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_value(out_value), .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int dv(input logic [1:0] c);
        return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
    endfunction

    function automatic logic [1:0] enc(input int v);
        return v == 1 ? 2'b01 : v == -1 ? 2'b11 : 2'b00;
    endfunction

    function automatic exp_t model(input logic [2*N-1:0] a, input logic [2*N-1:0] b, input logic cin);
        exp_t r;
        int z, pv, s, val, ar;
        int t[N];
        int w[N];
        r = '0;
        for (int i = 0; i < N; i++)
            if (a[2*i+:2] == 2'b10 || b[2*i+:2] == 2'b10) r.err = 1'b1;
        if (r.err) return r;
        val = 0;
        ar  = int'(cin);
        for (int i = 0; i < N; i++) begin
            z  = dv(a[2*i+:2]) + dv(b[2*i+:2]);
            ar = ar + z * (1 << i);
            pv = 0;
            if (i > 0) pv = (dv(a[2*i-2+:2]) < 0 || dv(b[2*i-2+:2]) < 0) ? 1 : 0;
            if (z == 2)       begin t[i] = 1;  w[i] = 0; end
            else if (z == -2) begin t[i] = -1; w[i] = 0; end
            else if (z == 0)  begin t[i] = 0;  w[i] = 0; end
            else if (z == 1)  begin t[i] = pv ? 0 : 1;   w[i] = pv ? 1 : -1; end
            else              begin t[i] = pv ? -1 : 0;  w[i] = pv ? 1 : -1; end
        end
        for (int i = 0; i < N; i++) begin
            if (i == 0) s = w[0] + int'(cin);
            else        s = w[i] + t[i-1];
            r.sum[2*i+:2] = enc(s);
            val = val + s * (1 << i);
        end
        r.cout  = enc(t[N-1]);
        val     = val + t[N-1] * (1 << N);
        r.value = (N+2)'(val);
        r.ar    = (N+2)'(ar);
        return r;
    endfunction

    function automatic logic [2*N-1:0] rnd_op(input bit allow_bad);
        logic [2*N-1:0] r;
        int k;
        for (int i = 0; i < N; i++) begin
            k = $urandom_range(2);
            r[2*i+:2] = k == 0 ? 2'b00 : k == 1 ? 2'b01 : 2'b11;
            if (allow_bad && $urandom_range(39) == 0) r[2*i+:2] = 2'b10;
        end
        return r;
    endfunction

    // scoreboard: expected results queued on accept, checked on every output handshake
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q.delete();
                held  = 0;
                cnt_m = 0;
            end else begin
                chk("err_cnt", err_cnt, cnt_m);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("unexpected_out", out_valid, 0);
                    else begin
                        e = q.pop_front();
                        chk("out_sum", out_sum, e.sum);
                        chk("out_cout", out_cout, e.cout);
                        chk("out_value", out_value, e.value);
                        chk("out_err", out_err, e.err);
                        if (!e.err) chk("value_arith", out_value, e.ar);
                        n_out++;
                    end
                end
                if (out_valid && !out_ready) begin
                    if (held) chk("stall_stable", {out_sum, out_cout, out_value, out_err}, h);
                    h    = {out_sum, out_cout, out_value, out_err};
                    held = 1;
                end else held = 0;
                mm = model(in_a, in_b, in_cin);
                if (in_valid && in_ready) q.push_back(mm);
                if (err_clr) cnt_m = 0;
                else if (in_valid && in_ready && mm.err && cnt_m < 255) cnt_m++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2*N-1:0] a, input logic [2*N-1:0] b, input logic c);
        int k = 0;
        in_a = a; in_b = b; in_cin = c; in_valid = 1;
        #1;
        while (!in_ready && k < 100) begin tick; k++; end
        chk("accept_wait", in_ready, 1);
        tick;
        in_valid = 0;
    endtask

    task automatic direct(input string nm, input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                          input logic c, input logic [2*N-1:0] es, input logic [1:0] ec,
                          input logic [N+1:0] ev, input logic ee);
        send(a, b, c);
        chk({nm, "_lat1"}, out_valid, 0);
        tick;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_sum"}, out_sum, es);
        chk({nm, "_cout"}, out_cout, ec);
        chk({nm, "_value"}, out_value, ev);
        chk({nm, "_err"}, out_err, ee);
    endtask

    initial begin
        bit fire;
        int acc, n0, sent;
        // model pins against hand-computed values
        mm = model(8'b00000001, 8'b00000001, 0);
        chk("pin1_sum", mm.sum, 8'b00000100);
        chk("pin1_value", mm.value, 6'd2);
        mm = model(8'b01010101, 8'b01010101, 1);
        chk("pin2_sum", mm.sum, 8'b01010101);
        chk("pin2_cout", mm.cout, 2'b01);
        chk("pin2_value", mm.value, 6'd31);
        mm = model(8'b00000100, 8'b00000011, 0);
        chk("pin3_sum", mm.sum, 8'b00000111);
        chk("pin3_value", mm.value, 6'd1);
        mm = model(8'b00000010, 8'b00000000, 0);
        chk("pin4_err", mm.err, 1);

        repeat (3) tick;
        rst = 0;
        mon_en = 1;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {out_sum, out_cout, out_value, out_err}, 0);
        chk("rst_err_cnt", err_cnt, 0);

        direct("t1", 8'b00000001, 8'b00000001, 0, 8'b00000100, 2'b00, 6'd2, 0);
        direct("t2", 8'b01010101, 8'b01010101, 1, 8'b01010101, 2'b01, 6'd31, 0);
        direct("t3", 8'b00000100, 8'b00000011, 0, 8'b00000111, 2'b00, 6'd1, 0);
        direct("t4", 8'b00000010, 8'b00000001, 0, 8'b00000000, 2'b00, 6'd0, 1);
        chk("t4_cnt1", err_cnt, 1);
        err_clr = 1;
        send(8'b10000000, 8'b00000000, 0);
        err_clr = 0;
        chk("t4_clr", err_cnt, 0);
        repeat (3) tick;

        // backpressure
        out_ready = 0;
        acc = 0;
        in_a = rnd_op(0); in_b = rnd_op(0); in_cin = 1'($urandom_range(1)); in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            fire = in_ready;
            if (fire) acc++;
            tick;
            if (fire) begin in_a = rnd_op(0); in_b = rnd_op(0); in_cin = 1'($urandom_range(1)); end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 0;
        n0 = n_out;
        out_ready = 1;
        tick;
        tick;
        chk("bp_drain", n_out - n0, 2);
        chk("bp_empty", out_valid, 0);

        // reset with two transactions in flight
        in_a = rnd_op(0); in_b = rnd_op(0); in_valid = 1;
        tick;
        in_a = 8'b00100000;
        tick;
        in_valid = 0;
        chk("rst6_cnt_pre", err_cnt, 1);
        rst = 1;
        tick;
        rst = 0;
        chk("rst6_out_valid", out_valid, 0);
        chk("rst6_err_cnt", err_cnt, 0);
        repeat (6) tick;
        chk("rst6_no_stale", out_valid, 0);

        // randomized traffic
        fire = 0;
        sent = 0;
        for (int c = 0; c < 4000 && (sent < 400 || in_valid); c++) begin
            if (!in_valid || fire) begin
                if (sent < 400 && $urandom_range(9) < 7) begin
                    in_a = rnd_op(1); in_b = rnd_op(1); in_cin = 1'($urandom_range(1));
                    in_valid = 1;
                    sent++;
                end else in_valid = 0;
            end
            out_ready = $urandom_range(9) < 7;
            err_clr = $urandom_range(29) == 0;
            #1;
            fire = in_valid && in_ready;
            tick;
        end
        in_valid = 0; err_clr = 0; out_ready = 1;
        repeat (5) tick;
        chk("rand_drained", q.size(), 0);

        // saturation of the error counter
        in_a = 8'b00000010; in_b = 8'b0; in_valid = 1;
        repeat (260) tick;
        in_valid = 0;
        repeat (3) tick;
        chk("err_sat", err_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
